// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters; same-cycle lookup, update from ID resolution.
// Optional BP_STATS_EN builds resolved-branch / misprediction counters.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_if,
  output logic            pred_taken_if,
  output logic [XLEN-1:0] pred_target_if,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0][TAGW-1:0]  tag_q;
  logic [ENTRIES-1:0][XLEN-1:0]  target_q;
  logic [ENTRIES-1:0][CTR_W-1:0] ctr_q;

  logic [IDXW-1:0] lk_idx, upd_idx;
  logic [TAGW-1:0] lk_tag, upd_tag;
  logic            lk_hit, upd_hit;
  logic [1:0]      unused_pc_bits;

  assign lk_idx  = pc_if[IDXW+1:2];
  assign lk_tag  = pc_if[XLEN-1:IDXW+2];
  assign upd_idx = upd_pc[IDXW+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDXW+2];
  assign unused_pc_bits = pc_if[1:0];

  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Reads see registered state, so a same-cycle update at this index is not yet visible.
  assign pred_taken_if  = lk_hit & ctr_q[lk_idx][CTR_W-1];
  assign pred_target_if = lk_hit ? target_q[lk_idx] : '0;

  assign mispredict  = upd_valid & ((upd_taken != upd_pred_taken) |
                       (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));
  assign redirect_pc = !mispredict ? '0 :
                       upd_taken   ? upd_target : upd_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != CTR_MAX) ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_W'(1);
          target_q[upd_idx] <= upd_target;
        end else if (ctr_q[upd_idx] != '0) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_W'(1);
        end
      end else if (upd_taken) begin
        // Not-taken misses never allocate; taken misses evict whatever aliases here.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= CTR_WT;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid && stat_branches != '1)  stat_branches    <= stat_branches + 32'd1;
      if (mispredict && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=64, XLEN=32, CTR_W=2).
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_if;
  logic        pred_taken_if;
  logic [31:0] pred_target_if;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.ENTRIES(64), .XLEN(32), .CTR_W(2)) dut (
    .clk(clk), .reset(reset), .pc_if(pc_if),
    .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
    #1;
  endtask

  task automatic idle();
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0;
  endtask

  task automatic look(input logic [31:0] pc);
    pc_if = pc;
    #1;
  endtask

  initial begin
    reset = 1'b1; pc_if = '0; idle();
    tick(); tick();
    reset = 1'b0;
    look(32'h0040_0000);
    check("cold_taken", 32'(pred_taken_if), 32'd0);
    check("cold_target", pred_target_if, 32'h0);
    check("rst_mispredict", 32'(mispredict), 32'd0);
    check("rst_redirect", redirect_pc, 32'h0);
    check("rst_stat_br", stat_branches, 32'd0);
    check("rst_stat_mp", stat_mispredicts, 32'd0);

    // First taken branch allocates; same-cycle lookup still sees the old (empty) entry.
    upd(32'h0040_000C, 1'b1, 32'h0040_0000, 1'b0, 32'h0);
    look(32'h0040_000C);
    check("alloc_mispredict", 32'(mispredict), 32'd1);
    check("alloc_redirect", redirect_pc, 32'h0040_0000);
    check("alloc_samecyc_taken", 32'(pred_taken_if), 32'd0);
    tick(); idle(); #1;
    check("alloc_taken", 32'(pred_taken_if), 32'd1);
    check("alloc_target", pred_target_if, 32'h0040_0000);

    // Two correctly predicted taken updates: ctr 2 -> 3 -> 3.
    upd(32'h0040_000C, 1'b1, 32'h0040_0000, 1'b1, 32'h0040_0000);
    check("hit_ok_mispredict", 32'(mispredict), 32'd0);
    check("hit_ok_redirect", redirect_pc, 32'h0);
    tick();
    upd(32'h0040_000C, 1'b1, 32'h0040_0000, 1'b1, 32'h0040_0000);
    tick();

    // Not-taken: ctr 3 -> 2, still taken.
    upd(32'h0040_000C, 1'b0, 32'h0, 1'b1, 32'h0040_0000);
    check("nt1_mispredict", 32'(mispredict), 32'd1);
    check("nt1_redirect", redirect_pc, 32'h0040_0010);
    tick(); idle(); #1;
    check("nt1_taken", 32'(pred_taken_if), 32'd1);

    // Second not-taken: ctr 2 -> 1; lookup in the update cycle returns the old prediction.
    upd(32'h0040_000C, 1'b0, 32'h0, 1'b1, 32'h0040_0000);
    check("samecyc_old_taken", 32'(pred_taken_if), 32'd1);
    tick(); idle(); #1;
    check("nt2_taken", 32'(pred_taken_if), 32'd0);
    check("nt2_target_kept", pred_target_if, 32'h0040_0000);

    // Floor saturation: ctr 1 -> 0 -> 0.
    upd(32'h0040_000C, 1'b0, 32'h0, 1'b0, 32'h0);
    check("nt3_mispredict", 32'(mispredict), 32'd0);
    tick();
    upd(32'h0040_000C, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); idle(); #1;
    check("floor_taken", 32'(pred_taken_if), 32'd0);

    // Not-taken mispredict on a miss: redirect to fall-through, no allocation.
    upd(32'h0040_0020, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
    check("nt_miss_mispredict", 32'(mispredict), 32'd1);
    check("nt_miss_redirect", redirect_pc, 32'h0040_0024);
    tick(); idle();
    look(32'h0040_0020);
    check("nt_miss_noalloc_taken", 32'(pred_taken_if), 32'd0);
    check("nt_miss_noalloc_target", pred_target_if, 32'h0);

    // Aliasing at index 3: 0x0040010C misses against 0x0040000C, then evicts it.
    look(32'h0040_010C);
    check("alias_miss_target", pred_target_if, 32'h0);
    upd(32'h0040_010C, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
    tick(); idle();
    look(32'h0040_010C);
    check("alias_new_taken", 32'(pred_taken_if), 32'd1);
    check("alias_new_target", pred_target_if, 32'h0040_0100);
    look(32'h0040_000C);
    check("alias_old_evicted", pred_target_if, 32'h0);

    // Taken with wrong predicted target.
    upd(32'h0040_010C, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0100);
    check("tgt_mispredict", 32'(mispredict), 32'd1);
    check("tgt_redirect", redirect_pc, 32'h0040_0200);
    tick(); idle();
    look(32'h0040_010C);
    check("tgt_updated", pred_target_if, 32'h0040_0200);

    // Fall-through wraps at the top of the address space.
    upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1000);
    check("wrap_mispredict", 32'(mispredict), 32'd1);
    check("wrap_redirect", redirect_pc, 32'h0);
    tick(); idle(); #1;

`ifdef BP_STATS_EN
    check("stat_branches", stat_branches, 32'd11);
    check("stat_mispredicts", stat_mispredicts, 32'd7);
`else
    check("stat_branches_tied", stat_branches, 32'd0);
    check("stat_mispredicts_tied", stat_mispredicts, 32'd0);
`endif

    // Reset beats a simultaneous taken update and clears everything.
    reset = 1'b1;
    upd(32'h0040_0040, 1'b1, 32'h0040_0800, 1'b0, 32'h0);
    tick();
    reset = 1'b0; idle();
    look(32'h0040_0040);
    check("rst_prio_taken", 32'(pred_taken_if), 32'd0);
    check("rst_prio_target", pred_target_if, 32'h0);
    look(32'h0040_010C);
    check("rst_clear_target", pred_target_if, 32'h0);
    check("rst_stat_br2", stat_branches, 32'd0);
    check("rst_stat_mp2", stat_mispredicts, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor and branch target buffer (BTB) for the 5-stage pipelined MIPS core. It gives fetch a same-cycle taken/not-taken prediction and target for the current PC. Each branch is resolved in decode; the block is updated from that resolution and flags mispredictions. It replaces static "predict not-taken, redirect from ID" with per-branch saturating counters.

## Interface
Parameters:
- ENTRIES, 64: table entries; power of two, ≥4.
- XLEN, 32: PC/target width.
- CTR_W, 2: saturating counter width, ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- pc_if  in  XLEN  fetch-stage PC being looked up.
- pred_taken_if  out  1  prediction for pc_if.
- pred_target_if  out  XLEN  predicted target for pc_if.
- upd_valid  in  1  a branch resolved in ID this cycle.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual taken target.
- upd_pred_taken  in  1  prediction made for this branch, carried through IF_ID.
- upd_pred_target  in  XLEN  predicted target carried through IF_ID.
- mispredict  out  1  redirect/flush request to fetch and IF_ID.
- redirect_pc  out  XLEN  correct next PC when mispredict=1.
- stat_branches  out  32  resolved-branch count (see Configuration).
- stat_mispredicts  out  32  misprediction count (see Configuration).

## Operation
- IDXW = log2(ENTRIES). Index = pc[IDXW+1:2]. Tag = pc[XLEN-1:IDXW+2]. PC bits [1:0] are ignored.
- Each entry holds valid, tag, target[XLEN], and ctr[CTR_W].
- Lookup is combinational from pc_if.
  - hit = valid & tag match.
  - pred_taken_if = hit & ctr[CTR_W-1].
  - pred_target_if = hit ? target : 0.
- When upd_valid=1, the entry at idx(upd_pc) is updated as follows:
  - On a hit with upd_taken=1: ctr is incremented, saturating at 2^CTR_W-1, and target is set to upd_target.
  - On a hit with upd_taken=0: ctr is decremented, saturating at 0; target is unchanged.
  - On a miss with upd_taken=1: the entry is allocated or overwritten. valid=1, tag is written, target=upd_target, ctr=2^(CTR_W-1) (weakly taken).
  - On a miss with upd_taken=0: no change; not-taken branches never allocate.
- mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target))).
- redirect_pc = upd_taken ? upd_target : upd_pc + 4, with XLEN-bit wrap. redirect_pc is 0 when mispredict=0.
- mispredict and redirect_pc are combinational. The core ORs mispredict into the IF_ID flush and uses redirect_pc as a PC mux input with priority over the prediction.

## Timing
- Prediction latency is 0 cycles: pred_* is valid in the same cycle as pc_if.
- Update is written at the rising edge ending the upd_valid cycle and is visible to lookups from the next cycle.
- If a lookup and an update hit the same index in the same cycle, the lookup returns the pre-update contents.
- While reset=1, at every edge:
  - all valid bits clear;
  - all ctr values are set to 2^(CTR_W-1)-1 (weakly not-taken);
  - targets are cleared;
  - stats are cleared;
  - update is suppressed.
- After reset, pred_taken_if=0, pred_target_if=0, mispredict=0, redirect_pc=0.
- Aliasing: when different tags share an index, a taken update from the new branch overwrites the entry.
- Reset takes priority over a simultaneous upd_valid.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments on every upd_valid cycle.
  - stat_mispredicts increments on every mispredict cycle.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- BP_STATS_EN undefined: the counters are not built and both ports are tied to 0. Port list is identical in both builds.

## Test plan
- Cold lookup: reset, then pc_if=0x00400000 → pred_taken_if=0, pred_target_if=0.
- First taken branch: upd_pc=0x0040000C, upd_taken=1, upd_target=0x00400000, upd_pred_taken=0 → mispredict=1, redirect_pc=0x00400000. Next cycle pc_if=0x0040000C → pred_taken_if=1, target 0x00400000.
- Hysteresis: after allocation (ctr=2), apply two taken updates → ctr=3. Then one not-taken update → still predicts taken. Then a second not-taken update → pred_taken_if=0.
- Not-taken mispredict and no allocation on miss:
  - upd_pred_taken=1, upd_taken=0, upd_pc=0x00400020 → redirect_pc=0x00400024.
  - A miss with a not-taken update leaves the entry invalid.
- Aliasing and same-cycle update:
  - ENTRIES=64: 0x0040000C is allocated, then 0x0040010C is looked up → miss, pred 0.
  - Lookup and update of 0x0040000C in the same cycle → old prediction returned.
- Stats (BP_STATS_EN): 5 updates with 2 mispredicts → stat_branches=5, stat_mispredicts=2. Asserting reset mid-sequence zeroes both.
